capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 158 +++++++++++++++
 tb/tb_capture_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Pulse-launch / settle / capture / UART-drain sequencer for one TDR acquisition.
// Define CAPSEQ_HEADER_EN to prefix each drain with a 0xA5, NUM_BYTES header.
module capture_sequencer #(
  parameter int NUM_BYTES     = 64,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       pulse_out,
  output logic       cap_en,
  input  logic [7:0] cap_data,
  input  logic       cap_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int AW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX    = 8'(NUM_BYTES - 1);

`ifdef CAPSEQ_HEADER_EN
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam logic [7:0] HDR_LEN  = 8'(NUM_BYTES);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_CAPTURE,
`ifdef CAPSEQ_HEADER_EN
    S_HEADER,
`endif
    S_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    wr_idx;
  logic [7:0]    rd_idx;
  logic          hdr_sel;
  logic [7:0]    buffer [NUM_BYTES];

  // Capture storage carries no reset; stale contents are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && cap_valid) begin
      buffer[wr_idx[AW-1:0]] <= cap_data;
    end
  end

  always_comb begin
    tx_data = buffer[rd_idx[AW-1:0]];
`ifdef CAPSEQ_HEADER_EN
    if (state == S_HEADER) begin
      tx_data = hdr_sel ? HDR_LEN : HDR_SYNC;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pulse_out <= 1'b0;
      cap_en    <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      hdr_sel   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_PULSE;
            pulse_out <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            hdr_sel   <= 1'b0;
          end
        end
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state     <= S_SETTLE;
            pulse_out <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state  <= S_CAPTURE;
            cap_en <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The last byte hands straight over to transmit; tx_valid rises with the state change.
        S_CAPTURE: begin
          if (cap_valid) begin
            wr_idx <= wr_idx + 8'd1;
            if (wr_idx == LAST_IDX) begin
              cap_en   <= 1'b0;
              tx_valid <= 1'b1;
`ifdef CAPSEQ_HEADER_EN
              state    <= S_HEADER;
`else
              state    <= S_DRAIN;
`endif
            end
          end
        end
`ifdef CAPSEQ_HEADER_EN
        S_HEADER: begin
          if (tx_ready) begin
            if (hdr_sel) begin
              state <= S_DRAIN;
            end else begin
              hdr_sel <= 1'b1;
            end
          end
        end
`endif
        S_DRAIN: begin
          if (tx_ready) begin
            if (rd_idx == LAST_IDX) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rd_idx <= rd_idx + 8'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: a 4-byte instance and a 1-byte instance.
// Expected tx bytes are queued by the stimulus tasks and consumed by a negedge monitor.
module tb_capture_sequencer;

  localparam int NB = 4;
  localparam int PC = 4;
  localparam int SC = 16;
`ifdef CAPSEQ_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic       pulse_out, cap_en, tx_valid, busy, done;
  logic [7:0] tx_data;

  logic       start1 = 1'b0;
  logic [7:0] cap_data1 = 8'h00;
  logic       cap_valid1 = 1'b0;
  logic       tx_ready1 = 1'b1;
  logic       pulse_out1, cap_en1, tx_valid1, busy1, done1;
  logic [7:0] tx_data1;

  int         checks = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int         xfer_total = 0;
  int         done_total = 0;
  int         xfer1_total = 0;
  int         done1_total = 0;
  int         ready_mode = 0;
  int         stall_at = -1;
  logic [7:0] vec [4];

  capture_sequencer #(.NUM_BYTES(NB), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .pulse_out(pulse_out), .cap_en(cap_en),
    .cap_data(cap_data), .cap_valid(cap_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  capture_sequencer #(.NUM_BYTES(1), .PULSE_CYCLES(2), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pulse_out(pulse_out1), .cap_en(cap_en1),
    .cap_data(cap_data1), .cap_valid(cap_valid1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented byte must match the queue head, which stays put through stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no transfer at %0t", tx_data, $time);
          end else begin
            checkOutput("tx_data", int'(tx_data), int'(exp_q[0]));
          end
          if (tx_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            xfer_total++;
          end
        end
        if (done) done_total++;
        if (tx_valid1) begin
          if (exp1_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL tx1_unexpected: got 0x%0h, expected no transfer at %0t", tx_data1, $time);
          end else begin
            checkOutput("tx1_data", int'(tx_data1), int'(exp1_q[0]));
          end
          if (tx_ready1) begin
            if (exp1_q.size() > 0) void'(exp1_q.pop_front());
            xfer1_total++;
          end
        end
        if (done1) done1_total++;
      end
    end
  end

  // Ready driver: mode 0 always ready, mode 1 random with one 50-cycle stall after stall_at transfers.
  initial begin
    int stall_left;
    int stalled_at;
    stall_left = 0;
    stalled_at = -1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        tx_ready = 1'b1;
      end else begin
        if (stall_left == 0 && xfer_total == stall_at && stalled_at != stall_at) begin
          stall_left = 50;
          stalled_at = stall_at;
        end
        if (stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_pulse_out"}, int'(pulse_out), 0);
    checkOutput({tag, "_cap_en"}, int'(cap_en), 0);
    checkOutput({tag, "_tx_valid"}, int'(tx_valid), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  task automatic applyStimulus(input bit stray_start, input bit stray_cap,
                               input bit rst_mid, input bit rand_ready);
    int n;
    int base_x;
    int base_d;
    base_x = xfer_total;
    base_d = done_total;
`ifdef CAPSEQ_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NB));
`endif
    foreach (vec[i]) exp_q.push_back(vec[i]);
    if (stray_cap) begin
      cap_data = 8'hFF;
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
      tick();
    end
    ready_mode = rand_ready ? 1 : 0;
    stall_at = xfer_total + 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (pulse_out && n < 100) begin
      start = (stray_start && n == 1);
      if (stray_cap) begin
        cap_data = 8'hFF;
        cap_valid = n[0];
      end
      n++;
      tick();
    end
    start = 1'b0;
    cap_valid = 1'b0;
    checkOutput("pulse_width", n, PC);
    n = 0;
    while (!cap_en && n < 100) begin
      start = (stray_start && n == 5);
      if (stray_cap) begin
        cap_data = 8'hFF;
        cap_valid = n[0];
      end
      n++;
      tick();
    end
    start = 1'b0;
    cap_valid = 1'b0;
    checkOutput("settle_gap", n, SC);
    foreach (vec[i]) begin
      repeat (7) tick();
      checkOutput("cap_en_during_capture", int'(cap_en), 1);
      cap_data = vec[i];
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
    end
    checkOutput("cap_en_after_last", int'(cap_en), 0);
    checkOutput("tx_valid_after_last", int'(tx_valid), 1);
    n = 0;
    while (!done && n < 2000) begin
      start = (stray_start && n == 1);
      if (rst_mid && (xfer_total - base_x) >= 2) begin
        start = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkIdleOutputs("in_reset");
        tick();
        tick();
        checkIdleOutputs("held_reset");
        rst = 1'b0;
        tick();
        checkOutput("no_done_on_reset", done_total, base_d);
        checkOutput("idle_after_reset", int'(busy), 0);
        return;
      end
      n++;
      tick();
    end
    start = 1'b0;
    checkOutput("done_seen", int'(done), 1);
    checkOutput("busy_at_done", int'(busy), 0);
    checkOutput("tx_valid_at_done", int'(tx_valid), 0);
    tick();
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("done_count", done_total, base_d + 1);
    checkOutput("xfer_count", xfer_total - base_x, NB + HDR);
    checkOutput("queue_empty", exp_q.size(), 0);
    ready_mode = 0;
    repeat (10) tick();
    checkOutput("no_restart", int'(busy), 0);
    checkOutput("done_count_settled", done_total, base_d + 1);
  endtask

  task automatic applyStimulus1();
    int n;
`ifdef CAPSEQ_HEADER_EN
    exp1_q.push_back(8'hA5);
    exp1_q.push_back(8'h01);
`endif
    exp1_q.push_back(8'h5C);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!cap_en1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("nb1_cap_en", int'(cap_en1), 1);
    cap_data1 = 8'h5C;
    cap_valid1 = 1'b1;
    tick();
    cap_valid1 = 1'b0;
    checkOutput("nb1_cap_en_off", int'(cap_en1), 0);
    n = 0;
    while (!done1 && n < 200) begin
      n++;
      tick();
    end
    checkOutput("nb1_done_seen", int'(done1), 1);
    tick();
    checkOutput("nb1_xfer_count", xfer1_total, 1 + HDR);
    checkOutput("nb1_done_count", done1_total, 1);
    checkOutput("nb1_queue_empty", exp1_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    repeat (3) tick();
    checkIdleOutputs("reset_state");
    rst = 1'b0;
    tick();
    $display("[TB] basic acquisition");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] random ready with long stall");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] start pulses while busy");
    vec = '{8'h3C, 8'hC3, 8'h5A, 8'h01};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    $display("[TB] stray cap_valid outside capture");
    vec = '{8'h80, 8'h7F, 8'h00, 8'hFE};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] reset mid-drain");
    vec = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] fresh acquisition after reset");
    vec = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] single-byte instance");
    applyStimulus1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
